// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the data-memory
// access controller.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dmem_state_e;
    typedef enum logic {OWN_CORE, OWN_DBG} dmem_owner_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Stores only have B/H/W forms; loads reject the three unused codes.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        return funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte/halfword lane logic: load extract with sign/zero extension and the
// store merge used by SB/SH read-modify-write.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] rbuf,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every always_comb output is assigned a default first, so no path infers a latch.
    always_comb begin
        byte_sel = rbuf[7:0];
        case (addr_lo)
            2'd0: byte_sel = rbuf[7:0];
            2'd1: byte_sel = rbuf[15:8];
            2'd2: byte_sel = rbuf[23:16];
            2'd3: byte_sel = rbuf[31:24];
            default: byte_sel = rbuf[7:0];
        endcase
        half_sel = addr_lo[1] ? rbuf[31:16] : rbuf[15:0];

        load_data = rbuf;
        case (funct3)
            F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: load_data = {24'h0, byte_sel};
            F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU: load_data = {16'h0, half_sel};
            default: load_data = rbuf;
        endcase

        merged = wdata;
        case (funct3)
            F3_B: begin
                merged = rbuf;
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged[7:0] = wdata[7:0];
                endcase
            end
            F3_H: begin
                merged = rbuf;
                if (addr_lo[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares a word-wide data memory between the core MEM stage and a debug port,
// sequencing loads, word stores and byte/half read-modify-write.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [2:0]            core_funct3,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    output logic                  core_stall,
    output logic                  core_done,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_err,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_done,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic [31:0]           mem_raddress,
    output logic [31:0]           mem_waddress,
    output logic [DATA_W-1:0]     mem_datain,
    output logic [3:0]            mem_wr,
    input  logic [DATA_W-1:0]     mem_dataout
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    dmem_state_e           state;
    dmem_owner_e           owner;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rbuf;
    logic                  err_q;
    logic [CNT_W-1:0]      starve_cnt;

    logic                  dbg_grant;
    logic                  sel_we;
    logic [2:0]            sel_f3;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_err;
    logic [31:0]           load_data;
    logic [31:0]           merged;

    // Debug accesses are always word-wide, so they reuse the SW/LW lane paths.
    assign dbg_grant = dbg_req && (!core_req || starve_cnt == CNT_W'(STARVE_LIMIT));
    assign sel_we    = dbg_grant ? dbg_we : core_we;
    assign sel_f3    = dbg_grant ? F3_W : core_funct3;
    assign sel_addr  = dbg_grant ? (dbg_addr & ~DM_ADDRESS'(3)) : core_addr;
    assign sel_wdata = dbg_grant ? dbg_wdata : core_wdata;
    assign sel_err   = !dbg_grant && (is_illegal(core_we, core_funct3) ||
                                      is_misaligned(core_funct3, core_addr[1:0]));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWN_CORE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req || dbg_req) begin
                        owner   <= dbg_grant ? OWN_DBG : OWN_CORE;
                        we_q    <= sel_we;
                        f3_q    <= sel_f3;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        err_q   <= sel_err;
                        if (sel_err)
                            state <= DONE;
                        else if (!sel_we || sel_f3 != F3_W)
                            state <= READ;
                        else
                            state <= WRITE;
                    end
                end
                READ: begin
                    rbuf  <= mem_dataout;
                    state <= we_q ? WRITE : DONE;
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Counts cycles a pending debug request loses; cleared while debug owns the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!dbg_req || (state == IDLE && dbg_grant) || (state != IDLE && owner == OWN_DBG))
            starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    dmem_lane_unit u_lane (
        .rbuf      (rbuf),
        .wdata     (wdata_q),
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    assign core_done  = (state == DONE) && (owner == OWN_CORE);
    assign dbg_done   = (state == DONE) && (owner == OWN_DBG);
    assign core_stall = core_req && !core_done;
    assign core_err   = core_done && err_q;
    assign core_rdata = (core_done && !err_q && !we_q) ? load_data : '0;
    assign dbg_rdata  = (dbg_done && !we_q) ? load_data : '0;

    assign mem_raddress = {{(32-DM_ADDRESS){1'b0}}, addr_q[DM_ADDRESS-1:2], 2'b00};
    assign mem_waddress = mem_raddress;
    assign mem_datain   = merged;
    assign mem_wr       = (state == WRITE) ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural word memory.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, core_stall, core_done, core_err;
    logic [2:0]  core_funct3;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_done;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic [31:0] mem_raddress, mem_waddress, mem_datain, mem_dataout;
    logic [3:0]  mem_wr;

    logic [31:0] mem [0:127];

    typedef struct {
        logic        dbg;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_dataout = mem[mem_raddress[8:2]];
    always @(posedge clk)
        if (mem_wr == 4'b1111) mem[mem_waddress[8:2]] <= mem_datain;

    dmem_access_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
        .core_done(core_done), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .mem_raddress(mem_raddress), .mem_waddress(mem_waddress),
        .mem_datain(mem_datain), .mem_wr(mem_wr), .mem_dataout(mem_dataout)
    );

    // Drives one core access and reports what the DUT returned; compares are done by callers.
    task automatic core_op(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                           input logic [31:0] wdata, output bit got, output int lat,
                           output logic [31:0] rdata, output logic err, output int wr_cnt,
                           output logic [31:0] wr_data, output bit stall_ok);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
        got = 0; lat = 0; wr_cnt = 0; wr_data = '0; stall_ok = 1; rdata = '0; err = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_wr == 4'b1111) begin wr_cnt++; wr_data = mem_datain; end
            if (core_done) begin got = 1; rdata = core_rdata; err = core_err; end
            else if (!core_stall) stall_ok = 0;
        end
        core_req = 1'b0;
    endtask

    task automatic dbg_op(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                          output bit got, output int lat, output logic [31:0] rdata);
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        got = 0; lat = 0; rdata = '0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (dbg_done) begin got = 1; rdata = dbg_rdata; end
        end
        dbg_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        core_req = 0; core_we = 0; core_funct3 = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        #12;
        n_tests++;
        if ({core_done, dbg_done, core_err, core_stall, mem_wr, core_rdata, dbg_rdata,
             mem_raddress, mem_waddress, mem_datain} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero (mem_wr=%h raddr=%h datain=%h), required all zero",
                     mem_wr, mem_raddress, mem_datain);
        end
        n_tests++;
        if (u_dut.state !== IDLE || u_dut.starve_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got state=%0d starve=%0d, required IDLE/0",
                     u_dut.state, u_dut.starve_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads;
        logic [31:0] words [6] = '{32'h8765_4321, 32'h80FF_0000, 32'h80FF_0000,
                                   32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000};
        logic [8:0]  addrs [6] = '{9'h010, 9'h013, 9'h013, 9'h012, 9'h012, 9'h012};
        logic [2:0]  f3s   [6] = '{F3_W, F3_B, F3_BU, F3_HU, F3_H, F3_B};
        logic [31:0] exps  [6] = '{32'h8765_4321, 32'hFFFF_FF80, 32'h0000_0080,
                                   32'h0000_80FF, 32'hFFFF_80FF, 32'hFFFF_FFFF};
        bit got, stall_ok; int lat, wr_cnt; logic [31:0] rd, wd; logic err; exp_t e;
        for (int i = 0; i < 6; i++) begin
            mem[addrs[i][8:2]] = words[i];
            exp_q.push_back('{dbg: 1'b0, rdata: exps[i], err: 1'b0, lat: 2});
            core_op(1'b0, f3s[i], addrs[i], 32'h0, got, lat, rd, err, wr_cnt, wd, stall_ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!got || lat != e.lat || rd !== e.rdata || err !== e.err || wr_cnt != 0 || !stall_ok) begin
                n_fail++;
                $display("FAIL load_%0d: got done=%0d lat=%0d rdata=%h err=%b writes=%0d stall_ok=%0d, required lat=%0d rdata=%h err=0 writes=0",
                         i, got, lat, rd, err, wr_cnt, stall_ok, e.lat, e.rdata);
            end
        end
    endtask

    task automatic test_stores;
        logic [8:0]  addrs [3] = '{9'h011, 9'h016, 9'h018};
        logic [2:0]  f3s   [3] = '{F3_B, F3_H, F3_W};
        logic [31:0] olds  [3] = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0};
        logic [31:0] wds   [3] = '{32'h0000_00AB, 32'h1234_BEEF, 32'hCAFE_F00D};
        logic [31:0] news  [3] = '{32'h1122_AB44, 32'hBEEF_CCDD, 32'hCAFE_F00D};
        int          lats  [3] = '{3, 3, 2};
        bit got, stall_ok; int lat, wr_cnt; logic [31:0] rd, wd; logic err; exp_t e;
        for (int i = 0; i < 3; i++) begin
            mem[addrs[i][8:2]] = olds[i];
            exp_q.push_back('{dbg: 1'b0, rdata: 32'h0, err: 1'b0, lat: lats[i]});
            core_op(1'b1, f3s[i], addrs[i], wds[i], got, lat, rd, err, wr_cnt, wd, stall_ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!got || lat != e.lat || rd !== e.rdata || err !== e.err) begin
                n_fail++;
                $display("FAIL store_%0d_done: got done=%0d lat=%0d rdata=%h err=%b, required lat=%0d rdata=0 err=0",
                         i, got, lat, rd, err, e.lat);
            end
            n_tests++;
            if (wr_cnt != 1 || wd !== news[i] || mem[addrs[i][8:2]] !== news[i]) begin
                n_fail++;
                $display("FAIL store_%0d_data: got writes=%0d datain=%h mem=%h, required 1 write of %h",
                         i, wr_cnt, wd, mem[addrs[i][8:2]], news[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic       wes   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] f3s   [4] = '{F3_W, 3'b011, 3'b011, F3_H};
        logic [8:0] addrs [4] = '{9'h012, 9'h010, 9'h010, 9'h013};
        bit got, stall_ok; int lat, wr_cnt; logic [31:0] rd, wd; logic err; exp_t e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{dbg: 1'b0, rdata: 32'h0, err: 1'b1, lat: 1});
            core_op(wes[i], f3s[i], addrs[i], 32'hFFFF_FFFF, got, lat, rd, err, wr_cnt, wd, stall_ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!got || lat != e.lat || rd !== e.rdata || err !== e.err || wr_cnt != 0) begin
                n_fail++;
                $display("FAIL error_%0d: got done=%0d lat=%0d rdata=%h err=%b writes=%0d, required lat=1 rdata=0 err=1 writes=0",
                         i, got, lat, rd, err, wr_cnt);
            end
        end
    endtask

    task automatic test_dbg;
        bit got, stall_ok; int lat, wr_cnt; logic [31:0] rd, wd; logic err; exp_t e;
        exp_q.push_back('{dbg: 1'b1, rdata: 32'h0, err: 1'b0, lat: 2});
        dbg_op(1'b1, 9'h05F, 32'hDEAD_BEEF, got, lat, rd);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || lat != e.lat || mem[9'h05C >> 2] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL dbg_write: got done=%0d lat=%0d mem=%h, required lat=2 mem=deadbeef",
                     got, lat, mem[9'h05C >> 2]);
        end
        exp_q.push_back('{dbg: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0, lat: 2});
        core_op(1'b0, F3_W, 9'h05C, 32'h0, got, lat, rd, err, wr_cnt, wd, stall_ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || lat != e.lat || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL dbg_readback: got done=%0d lat=%0d rdata=%h, required lat=2 rdata=%h",
                     got, lat, rd, e.rdata);
        end
    endtask

    task automatic test_arbitration;
        int core_cnt = 0; bit finished = 0; bit addr_ok = 1; exp_t e;
        mem[8]  = 32'h0BAD_F00D;
        mem[16] = 32'h5A5A_A5A5;
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{dbg: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0, lat: 0});
        exp_q.push_back('{dbg: 1'b1, rdata: 32'h5A5A_A5A5, err: 1'b0, lat: 0});
        @(negedge clk);
        core_req = 1; core_we = 0; core_funct3 = F3_W; core_addr = 9'h020;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h042;
        for (int c = 0; c < 60 && !finished; c++) begin
            @(negedge clk);
            if (mem_raddress[1:0] !== 2'b00) addr_ok = 0;
            if (core_done || dbg_done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL arb_order: unexpected done (core=%b dbg=%b), required none", core_done, dbg_done);
                end else begin
                    e = exp_q.pop_front();
                    if (dbg_done !== e.dbg || (e.dbg ? dbg_rdata : core_rdata) !== e.rdata) begin
                        n_fail++;
                        $display("FAIL arb_order: got dbg_done=%b core_rdata=%h dbg_rdata=%h after %0d core, required dbg=%b rdata=%h",
                                 dbg_done, core_rdata, dbg_rdata, core_cnt, e.dbg, e.rdata);
                    end
                end
                if (core_done) core_cnt++;
                if (dbg_done) begin
                    finished = 1;
                    core_req = 0;
                    dbg_req  = 0;
                    n_tests++;
                    if (u_dut.starve_cnt !== '0) begin
                        n_fail++;
                        $display("FAIL arb_starve_clear: got %0d, required 0", u_dut.starve_cnt);
                    end
                end
            end
        end
        core_req = 0; dbg_req = 0;
        n_tests++;
        if (!finished || core_cnt != 3 || !addr_ok) begin
            n_fail++;
            $display("FAIL arb_grant: got dbg_done=%0d core_before=%0d aligned=%0d, required 1/3/1",
                     finished, core_cnt, addr_ok);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_abort;
        bit got, stall_ok; int lat, wr_cnt; logic [31:0] rd, wd; logic err; exp_t e;
        bit saw_done = 0;
        mem[10] = 32'h1122_3344;
        @(negedge clk);
        core_req = 1; core_we = 1; core_funct3 = F3_B; core_addr = 9'h029; core_wdata = 32'h77;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (mem_wr !== 4'b1111) begin
            n_fail++;
            $display("FAIL abort_in_write: got mem_wr=%b, required 1111", mem_wr);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_wr !== 4'b0000 || u_dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL abort_async: got mem_wr=%b state=%0d, required 0000/IDLE", mem_wr, u_dut.state);
        end
        core_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (core_done || dbg_done) saw_done = 1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (core_done || dbg_done) saw_done = 1;
        end
        n_tests++;
        if (saw_done || mem[10] !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL abort_no_effect: got done_seen=%0d mem=%h, required 0/11223344", saw_done, mem[10]);
        end
        exp_q.push_back('{dbg: 1'b0, rdata: 32'h1122_3344, err: 1'b0, lat: 2});
        core_op(1'b0, F3_W, 9'h028, 32'h0, got, lat, rd, err, wr_cnt, wd, stall_ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || lat != e.lat || rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL abort_recover: got done=%0d lat=%0d rdata=%h err=%b, required lat=2 rdata=%h",
                     got, lat, rd, err, e.rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_dbg();
        test_arbitration();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
